// File: rtl/psum_accum_seq.sv
// psum_accum_seq: folds a variable-length stream of signed partial sums into a
// registered accumulator through a single approximate adder, then presents the
// final sum on a valid/ready output.
//
// Ports:
//   clk, rst_n     - clock (rising edge), asynchronous active-low reset
//   start_i, len_i - job start pulse and term count, sampled only in idle
//   busy_o         - high while a job is accumulating or waiting to deliver
//   in_valid_i / in_ready_o / in_data_i    - term input handshake
//   out_valid_o / out_ready_i / out_sum_o  - result output handshake
//
// add_approx: lower-part-copy approximate adder. The low approxBits of Sum are
// taken from B; the upper part is an exact add with carry-in A[approxBits-1].
// approxBits = 0 gives an exact adder with carry-in Cin.

module add_approx #(
    parameter int unsigned bitWidth   = 16,
    parameter int unsigned approxBits = 6
) (
    input  logic [bitWidth-1:0] A,
    input  logic [bitWidth-1:0] B,
    input  logic                Cin,
    output logic [bitWidth-1:0] Sum,
    output logic                Cout
);

    if (approxBits == 0) begin : g_exact
        assign {Cout, Sum} = {1'b0, A} + {1'b0, B} + {{bitWidth{1'b0}}, Cin};
    end else begin : g_approx
        localparam int unsigned HiW = bitWidth - approxBits;

        // Low bits of A only contribute through the carry guess; Cin is ignored.
        logic [approxBits:0] unused_bits;
        assign unused_bits = {A[approxBits-1:0], Cin};

        assign Sum[approxBits-1:0] = B[approxBits-1:0];
        assign {Cout, Sum[bitWidth-1:approxBits]} = {1'b0, A[bitWidth-1:approxBits]}
                                                  + {1'b0, B[bitWidth-1:approxBits]}
                                                  + {{HiW{1'b0}}, A[approxBits-1]};
    end

endmodule

module psum_accum_seq #(
    parameter int unsigned BIT_WIDTH   = 16,
    parameter int unsigned APPROX_BITS = 6,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start_i,
    input  logic [CNT_W-1:0]            len_i,
    output logic                        busy_o,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic signed [BIT_WIDTH-1:0] in_data_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic signed [BIT_WIDTH-1:0] out_sum_o
);

    typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

    state_e               state_q, state_d;
    logic [BIT_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]     rem_q, rem_d;
    logic [BIT_WIDTH-1:0] add_sum;
    logic                 unused_cout;

    // Operand order matters in approximate mode: acc on A, term on B.
    add_approx #(
        .bitWidth  (BIT_WIDTH),
        .approxBits(APPROX_BITS)
    ) u_add (
        .A   (acc_q),
        .B   (in_data_i),
        .Cin (1'b0),
        .Sum (add_sum),
        .Cout(unused_cout)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    acc_d   = '0;
                    rem_d   = len_i;
                    state_d = (len_i == '0) ? StDone : StAcc;
                end
            end
            StAcc: begin
                if (in_valid_i) begin
                    acc_d = add_sum;
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
        end
    end

    assign busy_o      = (state_q != StIdle);
    assign in_ready_o  = (state_q == StAcc);
    assign out_valid_o = (state_q == StDone);
    assign out_sum_o   = acc_q;

endmodule

// File: tb/tb_psum_accum_seq.sv
// Bench for psum_accum_seq: one default (approximate) instance and one exact
// instance share stimulus; expected sums are queued per instance and checked by
// an independent monitor on each output handshake.

module tb_psum_accum_seq;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [7:0]         len;
    logic               in_valid;
    logic signed [15:0] in_data;
    logic               out_ready;

    logic               busy_a, in_ready_a, out_valid_a;
    logic signed [15:0] out_sum_a;
    logic               busy_x, in_ready_x, out_valid_x;
    logic signed [15:0] out_sum_x;

    int n_cmp = 0;
    int n_err = 0;
    int q_a[$];
    int q_x[$];

    psum_accum_seq dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
        .len_i      (len),
        .busy_o     (busy_a),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready_a),
        .in_data_i  (in_data),
        .out_valid_o(out_valid_a),
        .out_ready_i(out_ready),
        .out_sum_o  (out_sum_a)
    );

    psum_accum_seq #(.APPROX_BITS(0)) dut_x (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
        .len_i      (len),
        .busy_o     (busy_x),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready_x),
        .in_data_i  (in_data),
        .out_valid_o(out_valid_x),
        .out_ready_i(out_ready),
        .out_sum_o  (out_sum_x)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int exp_a, input int exp_x);
        q_a.push_back(exp_a);
        q_x.push_back(exp_x);
    endtask

    // Scoreboard monitor: sample away from the active edge.
    always @(negedge clk) begin
        if (rst_n && out_valid_a && out_ready) begin
            if (q_a.size() == 0) chk("unexpected out_valid approx", 1, 0);
            else chk("out_sum approx", int'(out_sum_a), q_a.pop_front());
        end
        if (rst_n && out_valid_x && out_ready) begin
            if (q_x.size() == 0) chk("unexpected out_valid exact", 1, 0);
            else chk("out_sum exact", int'(out_sum_x), q_x.pop_front());
        end
    end

    bit v_pat[7]  = '{1, 0, 0, 1, 1, 0, 1};
    int terms[4]  = '{1, 2, 3, 4};

    initial begin
        int k;
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", int'(in_ready_a), 0);
        chk("reset out_valid", int'(out_valid_a), 0);
        chk("reset busy", int'(busy_a), 0);
        chk("reset out_sum", int'(out_sum_a), 0);
        rst_n = 1'b1;
        tick();

        // Job 1: three terms of 100; approx steps 100, 228, 356.
        push(356, 300);
        start = 1'b1; len = 8'd3;
        tick();
        start = 1'b0;
        chk("j1 in_ready after start", int'(in_ready_a), 1);
        chk("j1 busy after start", int'(busy_a), 1);
        in_valid = 1'b1; in_data = 16'sd100;
        tick();
        chk("j1 acc step1", int'($signed(dut_a.acc_q)), 100);
        tick();
        chk("j1 acc step2", int'($signed(dut_a.acc_q)), 228);
        chk("j1 out_valid early", int'(out_valid_a), 0);
        tick();
        in_valid = 1'b0;
        chk("j1 out_valid 4 cycles after start", int'(out_valid_a), 1);
        chk("j1 in_ready in done", int'(in_ready_a), 0);
        tick();
        chk("j1 idle after handshake", int'(busy_a), 0);

        // Job 2: wrap case, 32767 + 1.
        push(-32767, -32768);
        start = 1'b1; len = 8'd2;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 16'sd32767;
        tick();
        in_data = 16'sd1;
        tick();
        in_valid = 1'b0;
        chk("j2 out_valid", int'(out_valid_x), 1);
        tick();

        // Job 3: len 0, held result, start ignored in done.
        out_ready = 1'b0;
        push(0, 0);
        start = 1'b1; len = 8'd0;
        in_valid = 1'b1; in_data = 16'sd55;
        tick();
        chk("j3 out_valid one cycle after start", int'(out_valid_a), 1);
        chk("j3 in_ready stays low", int'(in_ready_a), 0);
        len = 8'd2;
        for (int i = 0; i < 10; i++) begin
            tick();
            start = 1'b0;
            chk("j3 hold out_valid", int'(out_valid_a), 1);
            chk("j3 hold out_sum", int'(out_sum_x), 0);
            chk("j3 hold in_ready", int'(in_ready_x), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("j3 idle after handshake", int'(busy_a), 0);

        // Job 4: gapped input, only valid beats count.
        push(4, 10);
        start = 1'b1; len = 8'd4;
        tick();
        start = 1'b0;
        k = 0;
        for (int i = 0; i < 7; i++) begin
            in_valid = v_pat[i];
            in_data  = v_pat[i] ? 16'(terms[k]) : 16'sd99;
            if (v_pat[i]) k++;
            tick();
            chk("j4 out_valid timing", int'(out_valid_x), (k == 4) ? 1 : 0);
        end
        in_valid = 1'b0;
        tick();

        // Job 5: reset mid-accumulation, then a fresh job.
        start = 1'b1; len = 8'd5;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 16'sd9;
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        chk("j5 busy drops in reset", int'(busy_a), 0);
        chk("j5 in_ready drops in reset", int'(in_ready_a), 0);
        chk("j5 out_valid in reset", int'(out_valid_x), 0);
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        push(7, 7);
        start = 1'b1; len = 8'd1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 16'sd7;
        tick();
        in_valid = 1'b0;
        chk("j5 out_valid new job", int'(out_valid_a), 1);
        tick();

        // Job 6: back-to-back; start in handshake cycle ignored, next cycle taken.
        push(5, 5);
        start = 1'b1; len = 8'd1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 16'sd5;
        tick();
        in_valid = 1'b0;
        start = 1'b1; len = 8'd3;
        tick();
        chk("j6 handshake-cycle start ignored", int'(busy_a), 0);
        push(1, 0);
        len = 8'd2;
        tick();
        start = 1'b0;
        chk("j6 second job accepted", int'(in_ready_a), 1);
        in_valid = 1'b1; in_data = -16'sd1;
        tick();
        in_data = 16'sd1;
        tick();
        in_valid = 1'b0;
        chk("j6 second out_valid", int'(out_valid_a), 1);
        tick();
        repeat (3) tick();

        chk("no extra out_valid", int'(out_valid_a), 0);
        chk("approx queue drained", q_a.size(), 0);
        chk("exact queue drained", q_x.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
